// File: rtl/i2c_slave_receiver_pkg.sv
// rtl/i2c_slave_receiver_pkg.sv - shared state encodings, ACK levels and default address for the I2C path
package i2c_slave_receiver_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ADDR     = 3'd1,
    ADDR_ACK = 3'd2,
    DATA     = 3'd3,
    DATA_ACK = 3'd4,
    IGNORE   = 3'd5
  } i2cState_e;

  localparam logic       I2C_ACK          = 1'b0;
  localparam logic       I2C_NACK         = 1'b1;
  localparam logic [6:0] DEFAULT_OWN_ADDR = 7'h50;

  // An ACK is signalled by pulling the open-drain line low.
  function automatic logic driveFor(input logic ackBit);
    return ackBit == I2C_ACK;
  endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// rtl/i2c_line_sync.sv - SCL/SDA synchronizer with edge and START/STOP detection
module i2c_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic scl,
  input  logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop,
  output logic sda_s
);

  logic [SYNC_STAGES-1:0] sclSync;
  logic [SYNC_STAGES-1:0] sdaSync;
  logic                   sclPrev;
  logic                   sdaPrev;
  logic                   sclS;

  // Chains reset to 1 so an idle bus produces no spurious edges.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sclSync <= '1;
      sdaSync <= '1;
      sclPrev <= 1'b1;
      sdaPrev <= 1'b1;
    end else begin
      sclSync <= {sclSync[SYNC_STAGES-2:0], scl};
      sdaSync <= {sdaSync[SYNC_STAGES-2:0], sda};
      sclPrev <= sclSync[SYNC_STAGES-1];
      sdaPrev <= sdaSync[SYNC_STAGES-1];
    end
  end

  assign sclS     = sclSync[SYNC_STAGES-1];
  assign sda_s    = sdaSync[SYNC_STAGES-1];
  assign scl_rise = sclS & ~sclPrev;
  assign scl_fall = ~sclS & sclPrev;
  // SCL must be high on both samples so an SDA change at an SCL edge is not a condition.
  assign start    = sclS & sclPrev & sdaPrev & ~sda_s;
  assign stop     = sclS & sclPrev & ~sdaPrev & sda_s;

endmodule

// File: rtl/i2c_slave_receiver.sv
// rtl/i2c_slave_receiver.sv - write-only I2C target: address match, data receive with ACK/NACK
module i2c_slave_receiver
  import i2c_slave_receiver_pkg::*;
#(
  parameter logic [6:0] OWN_ADDR    = DEFAULT_OWN_ADDR,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       scl,
  input  logic       sda,
  input  logic       rx_ready,
  output logic       sda_drive_low,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  output logic       stop_seen
);

  logic sclRise, sclFall, startCond, stopCond, sdaS;

  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) lineSync (
    .clock    (clock),
    .reset    (reset),
    .scl      (scl),
    .sda      (sda),
    .scl_rise (sclRise),
    .scl_fall (sclFall),
    .start    (startCond),
    .stop     (stopCond),
    .sda_s    (sdaS)
  );

  i2cState_e  state, stateNext;
  logic [2:0] bitCnt, cntNext;
  logic [7:0] shiftReg, shiftNext;
  logic       byteDone, byteDoneNext;
  logic       ackOk, ackOkNext;
  logic       busyNext, driveNext, rxValidNext, stopSeenNext;
  logic [7:0] rxDataNext;
  logic       respBit;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      bitCnt        <= 3'd0;
      shiftReg      <= 8'h00;
      byteDone      <= 1'b0;
      ackOk         <= 1'b0;
      busy          <= 1'b0;
      sda_drive_low <= 1'b0;
      rx_data       <= 8'h00;
      rx_valid      <= 1'b0;
      stop_seen     <= 1'b0;
    end else begin
      state         <= stateNext;
      bitCnt        <= cntNext;
      shiftReg      <= shiftNext;
      byteDone      <= byteDoneNext;
      ackOk         <= ackOkNext;
      busy          <= busyNext;
      sda_drive_low <= driveNext;
      rx_data       <= rxDataNext;
      rx_valid      <= rxValidNext;
      stop_seen     <= stopSeenNext;
    end
  end

  always_comb begin
    stateNext    = state;
    cntNext      = bitCnt;
    shiftNext    = shiftReg;
    byteDoneNext = byteDone;
    ackOkNext    = ackOk;
    busyNext     = busy;
    driveNext    = sda_drive_low;
    rxDataNext   = rx_data;
    rxValidNext  = 1'b0;
    stopSeenNext = 1'b0;
    respBit      = ackOk ? I2C_ACK : I2C_NACK;

    if (stopCond) begin
      stateNext    = IDLE;
      busyNext     = 1'b0;
      driveNext    = 1'b0;
      byteDoneNext = 1'b0;
      stopSeenNext = 1'b1;
    end else if (startCond) begin
      stateNext    = ADDR;
      cntNext      = 3'd0;
      busyNext     = 1'b0;
      driveNext    = 1'b0;
      byteDoneNext = 1'b0;
    end else begin
      case (state)
        ADDR: begin
          if (sclRise) begin
            shiftNext = {shiftReg[6:0], sdaS};
            cntNext   = bitCnt + 3'd1;
            if (bitCnt == 3'd7) begin
              if (shiftReg[6:0] == OWN_ADDR && sdaS == 1'b0) begin
                stateNext = ADDR_ACK;
                busyNext  = 1'b1;
              end else begin
                stateNext = IGNORE;
              end
            end
          end
        end
        // The drive flag doubles as the phase marker: first fall asserts, second releases.
        ADDR_ACK: begin
          if (sclFall) begin
            if (!sda_drive_low) begin
              driveNext = driveFor(I2C_ACK);
            end else begin
              driveNext    = 1'b0;
              stateNext    = DATA;
              cntNext      = 3'd0;
              byteDoneNext = 1'b0;
            end
          end
        end
        DATA: begin
          if (sclRise && !byteDone) begin
            shiftNext = {shiftReg[6:0], sdaS};
            cntNext   = bitCnt + 3'd1;
            if (bitCnt == 3'd7) begin
              byteDoneNext = 1'b1;
              ackOkNext    = rx_ready;
            end
          end else if (sclFall && byteDone) begin
            byteDoneNext = 1'b0;
            driveNext    = driveFor(respBit);
            if (ackOk) begin
              rxDataNext  = shiftReg;
              rxValidNext = 1'b1;
              stateNext   = DATA_ACK;
            end else begin
              busyNext  = 1'b0;
              stateNext = IGNORE;
            end
          end
        end
        DATA_ACK: begin
          if (sclFall) begin
            driveNext = 1'b0;
            stateNext = DATA;
            cntNext   = 3'd0;
          end
        end
        default: begin
          driveNext = 1'b0;
          busyNext  = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_slave_receiver.sv
// tb/tb_i2c_slave_receiver.sv - scoreboard bench driving an I2C master model into the target
module tb_i2c_slave_receiver;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       scl = 1'b1;
  logic       sdaM = 1'b1;
  logic       rxReady = 1'b1;
  logic       sdaBus;
  logic       sdaDriveLow;
  logic [7:0] rxData;
  logic       rxValid;
  logic       busy;
  logic       stopSeen;

  int checks = 0;
  int errors = 0;
  int stopCount = 0;
  int expStops = 0;
  int driveCount = 0;
  logic [7:0] expQ[$];

  assign sdaBus = sdaM & ~sdaDriveLow;

  always #5 clock = ~clock;

  i2c_slave_receiver #(.OWN_ADDR(7'h50), .SYNC_STAGES(2)) dut (
    .clock         (clock),
    .reset         (reset),
    .scl           (scl),
    .sda           (sdaBus),
    .rx_ready      (rxReady),
    .sda_drive_low (sdaDriveLow),
    .rx_data       (rxData),
    .rx_valid      (rxValid),
    .busy          (busy),
    .stop_seen     (stopSeen)
  );

  // Scoreboard monitor: every rx_valid pulse must match the oldest expected byte.
  always @(negedge clock) begin
    if (!reset) begin
      if (rxValid) begin
        checks++;
        if (expQ.size() == 0) begin
          errors++;
          $display("FAIL rx_unexpected: got rx_data=%02h, expected no rx_valid", rxData);
        end else begin
          logic [7:0] e;
          e = expQ.pop_front();
          if (rxData !== e) begin
            errors++;
            $display("FAIL rx_data: got %02h expected %02h", rxData, e);
          end
        end
      end
      if (stopSeen) stopCount++;
      if (sdaDriveLow) driveCount++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic quarter();
    #100;
  endtask

  task automatic startCond();
    sdaM = 1'b1; quarter();
    scl  = 1'b1; quarter();
    sdaM = 1'b0; quarter();
    scl  = 1'b0; quarter();
  endtask

  task automatic stopCond();
    sdaM = 1'b0; quarter();
    scl  = 1'b1; quarter();
    sdaM = 1'b1; quarter();
    expStops++;
  endtask

  task automatic writeBit(input logic b);
    sdaM = b;    quarter();
    scl  = 1'b1; quarter(); quarter();
    scl  = 1'b0; quarter();
  endtask

  task automatic sendByte(input logic [7:0] b, input logic expAck, input string name);
    for (int i = 7; i >= 0; i--) writeBit(b[i]);
    sdaM = 1'b1; quarter();
    scl  = 1'b1; quarter();
    check(name, sdaBus, expAck);
    quarter();
    scl  = 1'b0; quarter();
  endtask

  initial begin
    int d0;
    logic [7:0] addrByte;

    repeat (3) @(posedge clock);
    #1;
    check("reset_sda_drive_low", sdaDriveLow, 1'b0);
    check("reset_rx_data", rxData, 8'h00);
    check("reset_rx_valid", rxValid, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_stop_seen", stopSeen, 1'b0);
    reset = 1'b0;
    quarter();

    // Two-byte write with STOP
    startCond();
    sendByte(8'hA0, 1'b0, "t1_addr_ack");
    check("t1_busy_after_match", busy, 1'b1);
    expQ.push_back(8'h3C);
    sendByte(8'h3C, 1'b0, "t1_data0_ack");
    expQ.push_back(8'hC3);
    sendByte(8'hC3, 1'b0, "t1_data1_ack");
    stopCond();
    check("t1_busy_after_stop", busy, 1'b0);
    check("t1_stop_count", stopCount, 1);

    // Foreign address: never driven
    d0 = driveCount;
    startCond();
    sendByte(8'hA2, 1'b1, "t2_addr_nack");
    sendByte(8'h12, 1'b1, "t2_data_nack");
    check("t2_busy", busy, 1'b0);
    check("t2_no_drive", driveCount - d0, 0);
    stopCond();

    // Read request to own address: NACK and ignore
    d0 = driveCount;
    startCond();
    sendByte(8'hA1, 1'b1, "t3_read_nack");
    sendByte(8'h77, 1'b1, "t3_data_nack");
    check("t3_busy", busy, 1'b0);
    check("t3_no_drive", driveCount - d0, 0);
    stopCond();

    // Sink back-pressure on the second data byte
    startCond();
    sendByte(8'hA0, 1'b0, "t4_addr_ack");
    expQ.push_back(8'h11);
    sendByte(8'h11, 1'b0, "t4_data0_ack");
    rxReady = 1'b0;
    sendByte(8'h22, 1'b1, "t4_data1_nack");
    rxReady = 1'b1;
    check("t4_busy_ignore", busy, 1'b0);
    sendByte(8'h33, 1'b1, "t4_data2_ignored");
    stopCond();

    // Repeated START cuts a byte after 4 bits
    startCond();
    sendByte(8'hA0, 1'b0, "t5_addr_ack");
    writeBit(1'b1); writeBit(1'b0); writeBit(1'b1); writeBit(1'b1);
    startCond();
    check("t5_busy_after_rstart", busy, 1'b0);
    sendByte(8'hA0, 1'b0, "t5_addr2_ack");
    expQ.push_back(8'h55);
    sendByte(8'h55, 1'b0, "t5_data_ack");
    check("t5_rx_data_held", rxData, 8'h55);
    stopCond();

    // Reset while the target pulls SDA low in the address ACK slot
    startCond();
    addrByte = 8'hA0;
    for (int i = 7; i >= 0; i--) writeBit(addrByte[i]);
    sdaM = 1'b1; quarter();
    check("t6_drive_before_reset", sdaDriveLow, 1'b1);
    reset = 1'b1;
    #1;
    check("t6_drive_async_release", sdaDriveLow, 1'b0);
    check("t6_busy_reset", busy, 1'b0);
    check("t6_rx_data_reset", rxData, 8'h00);
    check("t6_rx_valid_reset", rxValid, 1'b0);
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    quarter();
    startCond();
    sendByte(8'hA0, 1'b0, "t6_addr_ack_after_reset");
    expQ.push_back(8'h9A);
    sendByte(8'h9A, 1'b0, "t6_data_ack");
    stopCond();

    repeat (20) @(posedge clock);
    #1;
    check("final_queue_empty", expQ.size(), 0);
    check("final_stop_count", stopCount, expStops);
    check("final_busy", busy, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
